mult_op_sequencer: RTL and testbench

// Command-driven controller for the precision-configurable 32x16 SIMD multiplier
// (16x16 / sum-16x8 / sum-8x4 modes). Accepts one operation per handshake, registers
// and drives mode, operands and signs, captures results into a held response.

---
 rtl/mult_op_sequencer.sv | 112 +++++++++++
 tb/tb_mult_op_sequencer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mult_op_sequencer.sv
// mult_op_sequencer: command/response sequencer for the 32x16 SIMD multiplier, incl. two-pass 32x16 long multiply.
// Define MULT_OP_SEQ_STATS_EN to add stat_ops/stat_stall counters.
module mult_op_sequencer #(
  parameter int OUT_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [31:0]      cmd_a,
  input  logic [15:0]      cmd_b,
  input  logic             cmd_a_sign,
  input  logic             cmd_b_sign,
  output logic [31:0]      mul_a,
  output logic [15:0]      mul_b,
  output logic             mul_a_sign,
  output logic             mul_b_sign,
  output logic [1:0]       mul_mode,
  input  logic [31:0]      mul_result_0,
  input  logic [31:0]      mul_result_1,
  input  logic [1:0]       mul_carry,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [OUT_W-1:0] rsp_data,
  output logic [1:0]       rsp_carry
`ifdef MULT_OP_SEQ_STATS_EN
  ,
  output logic [15:0]      stat_ops,
  output logic [15:0]      stat_stall
`endif
);
  typedef enum logic [2:0] {IDLE, EXEC, PASS0, PASS1, RESP} state_t;
  state_t state, next;
  logic [1:0] op_q;
  logic a_sign_q, b_sign_q;
  logic [15:0] a_hi_q;
  logic [31:0] p, p0;
  logic [47:0] prod48;
  logic start, long_op;
  assign p = {mul_result_1[31:20], mul_result_0[19:0]};
  // low pass P0 is unsigned in A, so it only sign-extends when B is signed
  assign prod48 = {p, 16'b0} + {{16{b_sign_q & p0[31]}}, p0};
  assign long_op = cmd_op == 2'b11;
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = cmd_valid ? (long_op ? PASS0 : EXEC) : IDLE;
      EXEC:    next = RESP;
      PASS0:   next = PASS1;
      PASS1:   next = RESP;
      RESP:    next = rsp_ready ? IDLE : RESP;
      default: next = IDLE;
    endcase
    cmd_ready = state == IDLE;
    rsp_valid = state == RESP;
    start = cmd_ready & cmd_valid;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= next;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      op_q <= '0;
      a_sign_q <= 1'b0;
      b_sign_q <= 1'b0;
      a_hi_q <= '0;
      p0 <= '0;
      mul_a <= '0;
      mul_b <= '0;
      mul_a_sign <= 1'b0;
      mul_b_sign <= 1'b0;
      mul_mode <= '0;
      rsp_data <= '0;
      rsp_carry <= '0;
    end else begin
      if (start) begin
        op_q <= cmd_op;
        a_sign_q <= cmd_a_sign;
        b_sign_q <= cmd_b_sign;
        a_hi_q <= cmd_a[31:16];
        mul_a <= long_op ? {16'b0, cmd_a[15:0]} : cmd_a;
        mul_b <= cmd_b;
        mul_a_sign <= cmd_a_sign & ~long_op;
        mul_b_sign <= cmd_b_sign;
        mul_mode <= long_op ? 2'b00 : cmd_op;
      end
      if (state == PASS0) begin
        p0 <= p;
        mul_a <= {16'b0, a_hi_q};
        mul_a_sign <= a_sign_q;
      end
      if (state == EXEC) begin
        rsp_data <= (op_q == 2'b00) ? {{32{(a_sign_q | b_sign_q) & p[31]}}, p} : {mul_result_1, mul_result_0};
        rsp_carry <= (op_q == 2'b00) ? 2'b00 : mul_carry;
      end
      if (state == PASS1) begin
        rsp_data <= {{16{(a_sign_q | b_sign_q) & prod48[47]}}, prod48};
        rsp_carry <= 2'b00;
      end
    end
`ifdef MULT_OP_SEQ_STATS_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      stat_ops <= '0;
      stat_stall <= '0;
    end else begin
      if (rsp_valid & rsp_ready) stat_ops <= stat_ops + 16'd1;
      if (rsp_valid & ~rsp_ready) stat_stall <= stat_stall + 16'd1;
    end
`endif
endmodule

// File: tb/tb_mult_op_sequencer.sv
// tb_mult_op_sequencer: random + directed ops against a plain-arithmetic reference, with a stub multiplier.
module tb_mult_op_sequencer;
  logic clk = 1'b0, reset = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready;
  logic [1:0] cmd_op = '0;
  logic [31:0] cmd_a = '0;
  logic [15:0] cmd_b = '0;
  logic cmd_a_sign = 1'b0, cmd_b_sign = 1'b0;
  logic [31:0] mul_a;
  logic [15:0] mul_b;
  logic mul_a_sign, mul_b_sign;
  logic [1:0] mul_mode;
  logic [31:0] mul_result_0, mul_result_1;
  logic [1:0] mul_carry;
  logic rsp_valid, rsp_ready = 1'b0;
  logic [63:0] rsp_data;
  logic [1:0] rsp_carry;
  int checks = 0, errors = 0;
  int st_ops = 0, st_stall = 0;
`ifdef MULT_OP_SEQ_STATS_EN
  logic [15:0] stat_ops, stat_stall;
`endif
  always #5 clk = ~clk;
  mult_op_sequencer dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_a_sign(cmd_a_sign), .cmd_b_sign(cmd_b_sign),
    .mul_a(mul_a), .mul_b(mul_b), .mul_a_sign(mul_a_sign), .mul_b_sign(mul_b_sign), .mul_mode(mul_mode),
    .mul_result_0(mul_result_0), .mul_result_1(mul_result_1), .mul_carry(mul_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_carry(rsp_carry)
`ifdef MULT_OP_SEQ_STATS_EN
    , .stat_ops(stat_ops), .stat_stall(stat_stall)
`endif
  );
  function automatic logic [31:0] mul16(input logic [15:0] a, input logic [15:0] b, input logic as, input logic bs);
    longint x, y, pr;
    x = as ? longint'($signed(a)) : longint'(a);
    y = bs ? longint'($signed(b)) : longint'(b);
    pr = x * y;
    return pr[31:0];
  endfunction
  // stub multiplier: real 16x16 product in mode 00 with junk in the unused bit fields, a fixed mix otherwise
  logic [31:0] p16;
  assign p16 = mul16(mul_a[15:0], mul_b, mul_a_sign, mul_b_sign);
  assign mul_result_0 = (mul_mode == 2'b00) ? {mul_a[31:20] ^ 12'hA5C, p16[19:0]} : mul_a ^ {mul_b, mul_b} ^ {30'b0, mul_mode};
  assign mul_result_1 = (mul_mode == 2'b00) ? {p16[31:20], mul_b, 4'h9} : mul_a + {16'b0, mul_b};
  assign mul_carry = (mul_mode == 2'b00) ? (mul_a[1:0] | 2'b01) : mul_a[17:16] ^ mul_b[1:0];
  function automatic logic [63:0] ref_data(input logic [1:0] op, input logic [31:0] a, input logic [15:0] b, input logic as, input logic bs);
    longint x, y;
    if (op == 2'd1 || op == 2'd2) return {a + {16'b0, b}, a ^ {b, b} ^ {30'b0, op}};
    x = (op == 2'd0) ? (as ? longint'($signed(a[15:0])) : longint'(a[15:0])) : (as ? longint'($signed(a)) : longint'(a));
    y = bs ? longint'($signed(b)) : longint'(b);
    return x * y;
  endfunction
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [15:0] b,
                        input logic as, input logic bs, input int stall, output logic [63:0] got);
    logic [63:0] exp_d, r_t1;
    logic [1:0] exp_c;
    int lat;
    exp_d = ref_data(op, a, b, as, bs);
    exp_c = (op == 2'd1 || op == 2'd2) ? a[17:16] ^ b[1:0] : 2'b00;
    @(negedge clk);
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_a_sign = as; cmd_b_sign = bs;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_a = $urandom; cmd_b = 16'($urandom); cmd_op = 2'($urandom); cmd_a_sign = 1'($urandom); cmd_b_sign = 1'($urandom);
    @(negedge clk);
    r_t1 = {mul_result_1, mul_result_0};
    check("busy_cmd_ready", cmd_ready, 0);
    check("busy_rsp_valid", rsp_valid, 0);
    check("t1_mul_mode", mul_mode, (op == 2'd3) ? 2'b00 : op);
    check("t1_mul_a", mul_a, (op == 2'd3) ? {16'b0, a[15:0]} : a);
    check("t1_mul_b", mul_b, b);
    check("t1_signs", {mul_a_sign, mul_b_sign}, {as & (op != 2'd3), bs});
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
      if (lat == 2 && op == 2'd3) begin
        check("pass1_mul_a", mul_a, {16'b0, a[31:16]});
        check("pass1_mode_signs", {mul_mode, mul_a_sign, mul_b_sign}, {2'b00, as, bs});
      end
    end
    check("latency", lat, (op == 2'd3) ? 3 : 2);
    check("rsp_data", rsp_data, exp_d);
    check("rsp_carry", rsp_carry, exp_c);
    if (op == 2'd1 || op == 2'd2) check("rsp_eq_t1_result", rsp_data, r_t1);
    got = rsp_data;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_valid", rsp_valid, 1);
      check("stall_data", {rsp_data[61:0], rsp_carry}, {exp_d[61:0], exp_c});
      check("stall_cmd_ready", cmd_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    st_ops++;
    st_stall += stall;
    @(negedge clk);
    check("post_rsp_valid", rsp_valid, 0);
    check("post_cmd_ready", cmd_ready, 1);
  endtask
  initial begin
    logic [63:0] got;
    logic seen;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rsp", {rsp_valid, rsp_data, rsp_carry}, 0);
    check("rst_mul", {mul_a, mul_b, mul_a_sign, mul_b_sign, mul_mode}, 0);
    reset = 1'b0;
    run_op(2'd0, 32'h0000FFFD, 16'h0007, 1, 1, 0, got);
    check("t1_const", got, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(2'd3, 32'h00010000, 16'h0003, 0, 0, 1, got);
    check("t2_const", got, 64'h30000);
    run_op(2'd3, 32'hFFFFFFFF, 16'hFFFF, 1, 1, 0, got);
    check("t3_const", got, 64'h1);
    run_op(2'd1, 32'h00020003, 16'h0504, 0, 0, 2, got);
    run_op(2'd2, 32'h80FF7F01, 16'hA5C3, 1, 0, 5, got);
    run_op(2'd0, 32'h12348000, 16'hFFFF, 1, 0, 0, got);
    run_op(2'd3, 32'h80000000, 16'hFFFF, 1, 0, 0, got);
    check("long_min_const", got, 64'hFFFF_8000_8000_0000);
    for (int n = 0; n < 40; n++)
      run_op(2'($urandom_range(0, 3)), $urandom, 16'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3), got);
`ifdef MULT_OP_SEQ_STATS_EN
    check("stat_ops_model", stat_ops, 16'(st_ops));
    check("stat_stall_model", stat_stall, 16'(st_stall));
`endif
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'd3; cmd_a = 32'h7654_3210; cmd_b = 16'h1357; cmd_a_sign = 1; cmd_b_sign = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("abort_cmd_ready", cmd_ready, 1);
    check("abort_rsp", {rsp_valid, rsp_data, rsp_carry}, 0);
    check("abort_mul", {mul_a, mul_b, mul_a_sign, mul_b_sign, mul_mode}, 0);
`ifdef MULT_OP_SEQ_STATS_EN
    check("abort_stats", {stat_ops, stat_stall}, 0);
`endif
    st_ops = 0;
    st_stall = 0;
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen |= rsp_valid;
    end
    check("abort_no_rsp", seen, 0);
    check("abort_idle_ready", cmd_ready, 1);
    run_op(2'd0, 32'h0000_0010, 16'h0010, 0, 0, 2, got);
    run_op(2'd1, 32'hDEAD_BEEF, 16'h0F0F, 0, 1, 3, got);
    run_op(2'd3, 32'h0001_0001, 16'h0002, 0, 0, 0, got);
    check("after_abort_long", got, 64'h2_0002);
`ifdef MULT_OP_SEQ_STATS_EN
    check("stat_ops_3", stat_ops, 16'd3);
    check("stat_stall_5", stat_stall, 16'd5);
    check("stat_model", {stat_ops, stat_stall}, {16'(st_ops), 16'(st_stall)});
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
